// File: rtl/keypad_pkg.sv
// Shared types and constants for the matrix keypad scanner.
package keypad_pkg;

  localparam logic [3:0] KEY_ALARM = 4'd10;
  localparam logic [3:0] KEY_TIME  = 4'd11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DEB_PRESS,
    ST_PRESSED,
    ST_DEB_RELEASE
  } state_e;

  typedef enum logic [1:0] {
    FR_NONE,
    FR_SINGLE,
    FR_MULTI
  } frame_e;

  // Key codes indexed by {row[1:0], col[1:0]}; col 3 does not exist on the pad.
  localparam logic [3:0] KEY_MAP [16] = '{
    4'd1,  4'd2, 4'd3,  4'd0,   // row 0
    4'd4,  4'd5, 4'd6,  4'd0,   // row 1
    4'd7,  4'd8, 4'd9,  4'd0,   // row 2
    4'd10, 4'd0, 4'd11, 4'd0    // row 3: alarm, 0, time
  };

  // Frame counters stop at their maximum rather than wrapping.
  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Keypad matrix lines plus the encoded key outputs toward the control FSM.
interface keypad_scanner_if;
  logic [2:0] col;
  logic [3:0] row_n;
  logic [3:0] key;
  logic       key_valid;
  logic       key_strobe;
  logic       alarm_button;
  logic       time_button;

  // The scanner: reads columns, drives rows and the key outputs.
  modport master (
    input  col,
    output row_n, key, key_valid, key_strobe, alarm_button, time_button
  );

  // The environment: keypad matrix and key consumer.
  modport slave (
    output col,
    input  row_n, key, key_valid, key_strobe, alarm_button, time_button
  );
endinterface

// File: rtl/keypad_col_sync.sv
// Two-flop synchroniser for the asynchronous, active-low column returns.
module keypad_col_sync (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] col_async,
  output logic [2:0] col_sync
);

  logic [2:0] meta_q, meta_d;
  logic [2:0] sync_q, sync_d;

  // Shift the raw columns through the two synchroniser stages.
  always_comb begin
    meta_d = col_async;
    sync_d = meta_q;
  end

  // Synchroniser registers; idle (all released) level is 3'b111.
  // NOTE: non-blocking assignments so both stages sample pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= 3'b111;
      sync_q <= 3'b111;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign col_sync = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x3 keypad scanner: row scan, per-frame classification, debounce FSM and
// key encoding with held valid level, one-cycle strobe and function-key levels.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV = 250,
  parameter int DEBOUNCE = 3
) (
  input logic               clk,
  input logic               reset,
  keypad_scanner_if.master  kp
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [3:0]       DEB_N    = 4'(DEBOUNCE);
  localparam bit               DEB_ONE  = (DEBOUNCE <= 1);

  logic [2:0] col_sync;

  keypad_col_sync u_col_sync (
    .clk       (clk),
    .reset     (reset),
    .col_async (kp.col),
    .col_sync  (col_sync)
  );

  logic [DIV_W-1:0] div_q, div_d;
  logic [1:0]       row_q, row_d;
  logic [3:0][2:0]  hits_q, hits_d;     // active-high hits per row, this frame
  logic             sample, frame_end;

  logic [3:0][2:0]  frame_hits;
  logic [3:0]       hit_cnt;
  logic [3:0]       hit_code;
  frame_e           frame_res;

  state_e           state_q, state_d;
  logic [3:0]       cand_q, cand_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [3:0]       key_q, key_d;
  logic             valid_q, valid_d;
  logic             strobe_q, strobe_d;
  logic             alarm_q, alarm_d;
  logic             time_q, time_d;

  logic             accept;
  logic             release_key;
  logic [3:0]       accept_code;

  // Row timing: hold each row for SCAN_DIV cycles, sample on its last cycle.
  // NOTE: every always_comb output gets a default first, so no path infers a latch.
  always_comb begin
    sample    = (div_q == DIV_LAST);
    frame_end = sample && (row_q == 2'd3);
    div_d     = sample ? '0 : div_q + 1'b1;
    row_d     = sample ? row_q + 2'd1 : row_q;
    hits_d    = hits_q;
    if (sample) hits_d[row_q] = ~col_sync;
  end

  // Classify the frame; row 3 comes straight from this cycle's sample.
  always_comb begin
    frame_hits    = hits_q;
    frame_hits[3] = ~col_sync;
    hit_cnt       = '0;
    hit_code      = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 3; c++) begin
        if (frame_hits[r][c]) begin
          hit_cnt  = hit_cnt + 4'd1;
          hit_code = KEY_MAP[4'(r * 4 + c)];
        end
      end
    end
    case (hit_cnt)
      4'd0:    frame_res = FR_NONE;
      4'd1:    frame_res = FR_SINGLE;
      default: frame_res = FR_MULTI;
    endcase
  end

  // Debounce FSM, advanced once per frame end; MULTI behaves like NONE.
  always_comb begin
    state_d     = state_q;
    cand_d      = cand_q;
    cnt_d       = cnt_q;
    accept      = 1'b0;
    release_key = 1'b0;
    accept_code = cand_q;

    if (frame_end) begin
      unique case (state_q)
        ST_IDLE: begin
          if (frame_res == FR_SINGLE) begin
            cand_d = hit_code;
            if (DEB_ONE) begin
              accept      = 1'b1;
              accept_code = hit_code;
            end else begin
              state_d = ST_DEB_PRESS;
              cnt_d   = 4'd1;
            end
          end
        end
        ST_DEB_PRESS: begin
          if (frame_res == FR_SINGLE && hit_code == cand_q) begin
            if (sat_inc4(cnt_q) >= DEB_N) accept = 1'b1;
            else cnt_d = sat_inc4(cnt_q);
          end else if (frame_res == FR_SINGLE) begin
            cand_d = hit_code;
            cnt_d  = 4'd1;
          end else begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end
        end
        ST_PRESSED: begin
          if (frame_res != FR_SINGLE) begin
            if (DEB_ONE) begin
              release_key = 1'b1;
            end else begin
              state_d = ST_DEB_RELEASE;
              cnt_d   = 4'd1;
            end
          end
        end
        ST_DEB_RELEASE: begin
          if (frame_res == FR_SINGLE) begin
            state_d = ST_PRESSED;
            cnt_d   = '0;
          end else if (sat_inc4(cnt_q) >= DEB_N) begin
            release_key = 1'b1;
          end else begin
            cnt_d = sat_inc4(cnt_q);
          end
        end
        default: state_d = ST_IDLE;
      endcase

      if (accept) begin
        state_d = ST_PRESSED;
        cnt_d   = '0;
      end
      if (release_key) begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    end
  end

  // Output levels: load on acceptance, drop on release, strobe for one cycle.
  always_comb begin
    key_d    = key_q;
    valid_d  = valid_q;
    strobe_d = 1'b0;
    alarm_d  = alarm_q;
    time_d   = time_q;
    if (accept) begin
      key_d    = accept_code;
      valid_d  = 1'b1;
      strobe_d = 1'b1;
      alarm_d  = (accept_code == KEY_ALARM);
      time_d   = (accept_code == KEY_TIME);
    end else if (release_key) begin
      valid_d  = 1'b0;
      alarm_d  = 1'b0;
      time_d   = 1'b0;
    end
  end

  // State registers; reset returns the scan, FSM and outputs to idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q    <= '0;
      row_q    <= '0;
      hits_q   <= '0;
      state_q  <= ST_IDLE;
      cand_q   <= '0;
      cnt_q    <= '0;
      key_q    <= '0;
      valid_q  <= 1'b0;
      strobe_q <= 1'b0;
      alarm_q  <= 1'b0;
      time_q   <= 1'b0;
    end else begin
      div_q    <= div_d;
      row_q    <= row_d;
      hits_q   <= hits_d;
      state_q  <= state_d;
      cand_q   <= cand_d;
      cnt_q    <= cnt_d;
      key_q    <= key_d;
      valid_q  <= valid_d;
      strobe_q <= strobe_d;
      alarm_q  <= alarm_d;
      time_q   <= time_d;
    end
  end

  assign kp.row_n        = ~(4'b0001 << row_q);
  assign kp.key          = key_q;
  assign kp.key_valid    = valid_q;
  assign kp.key_strobe   = strobe_q;
  assign kp.alarm_button = alarm_q;
  assign kp.time_button  = time_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: emulated key matrix, frame-level reference model
// and randomized key sequences on top of directed scenarios.
module tb_keypad_scanner;

  localparam int SCAN_DIV = 4;
  localparam int DEBOUNCE = 2;
  localparam int FRAME    = 4 * SCAN_DIV;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  keypad_scanner_if kif ();

  // Pressed keys, bit index row*3 + col (col 0 = left key).
  logic [11:0] pressed;

  // Passive matrix: a pressed key pulls its column low while its row is driven.
  always_comb begin
    kif.col = 3'b111;
    for (int r = 0; r < 4; r++) begin
      if (!kif.row_n[r]) kif.col = kif.col & ~pressed[r*3 +: 3];
    end
  end

  keypad_scanner #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEBOUNCE)) dut (
    .clk   (clk),
    .reset (reset),
    .kp    (kif.master)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: keypad legend and history of frame results (-1 = no single key).
  int         label [12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 0, 11};
  int         hist [$];
  bit         held;
  logic [3:0] exp_key;
  bit         exp_strobe;

  function automatic int frame_code(input logic [11:0] k);
    int code;
    code = -1;
    if ($countones(k) == 1) begin
      for (int i = 0; i < 12; i++) if (k[i]) code = label[i];
    end
    return code;
  endfunction

  task automatic model_clear();
    hist.delete();
    held       = 0;
    exp_key    = 4'd0;
    exp_strobe = 0;
  endtask

  // A press is accepted once the last DEBOUNCE frames all show the same single
  // key; a held key is released once the last DEBOUNCE frames show none.
  task automatic model_frame(input logic [11:0] k);
    bit all_same;
    hist.push_back(frame_code(k));
    if (hist.size() > DEBOUNCE) void'(hist.pop_front());
    exp_strobe = 0;
    if (hist.size() == DEBOUNCE) begin
      all_same = 1;
      foreach (hist[i]) if (hist[i] != hist[0]) all_same = 0;
      if (!held && all_same && hist[0] >= 0) begin
        held       = 1;
        exp_key    = 4'(hist[0]);
        exp_strobe = 1;
      end else if (held && all_same && hist[0] < 0) begin
        held = 0;
      end
    end
  endtask

  task automatic check_outputs();
    check("key_strobe", kif.key_strobe, exp_strobe);
    check("key_valid", kif.key_valid, held);
    check("key", kif.key, exp_key);
    check("alarm_button", kif.alarm_button, held && exp_key == 4'd10);
    check("time_button", kif.time_button, held && exp_key == 4'd11);
  endtask

  // Entered at the negedge of a frame's first cycle; returns at the next one.
  task automatic run_frame(input logic [11:0] k);
    pressed = k;
    check_outputs();
    for (int c = 0; c < FRAME; c++) begin
      check("row_n", kif.row_n, ~(32'd1 << (c / SCAN_DIV)) & 32'hF);
      if (c != 0) check("strobe_quiet", kif.key_strobe, 0);
      @(negedge clk);
    end
    model_frame(k);
  endtask

  task automatic run_frames(input logic [11:0] k, input int n);
    for (int i = 0; i < n; i++) run_frame(k);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_row_n"}, kif.row_n, 4'b1110);
    check({tag, "_key"}, kif.key, 0);
    check({tag, "_key_valid"}, kif.key_valid, 0);
    check({tag, "_key_strobe"}, kif.key_strobe, 0);
    check({tag, "_alarm"}, kif.alarm_button, 0);
    check({tag, "_time"}, kif.time_button, 0);
  endtask

  // Reset released on a negedge, so the bench is then in cycle 0 of frame 0.
  task automatic release_reset();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_clear();
  endtask

  localparam logic [11:0] K_NONE  = 12'd0;
  localparam logic [11:0] K_1     = 12'b0000_0000_0001;
  localparam logic [11:0] K_3     = 12'b0000_0000_0100;
  localparam logic [11:0] K_5     = 12'b0000_0001_0000;
  localparam logic [11:0] K_7     = 12'b0000_0100_0000;
  localparam logic [11:0] K_ALARM = 12'b0010_0000_0000;
  localparam logic [11:0] K_TIME  = 12'b1000_0000_0000;

  initial begin
    logic [11:0] cur;
    int mode;

    pressed = K_NONE;
    reset   = 1'b1;
    #2;
    check_reset_values("reset");
    release_reset();

    // Idle scanning, no key.
    run_frames(K_NONE, 3);

    // Key 5 held for 5 frames, then released.
    run_frames(K_5, 5);
    run_frames(K_NONE, 4);

    // Key 7 present for one frame only.
    run_frames(K_7, 1);
    run_frames(K_NONE, 3);

    // Keys 1 and 3 together, then 3 released while 1 stays.
    run_frames(K_1 | K_3, 4);
    run_frames(K_1, 4);
    run_frames(K_NONE, 3);

    // Function keys.
    run_frames(K_ALARM, 4);
    run_frames(K_NONE, 3);
    run_frames(K_TIME, 4);
    run_frames(K_NONE, 3);

    // Reset while a key is held, then re-acceptance of the same key.
    run_frames(K_ALARM, 4);
    check("held_before_reset", kif.key_valid, 1);
    #2 reset = 1'b1;
    #1;
    check_reset_values("midreset");
    release_reset();
    run_frames(K_ALARM, 4);
    run_frames(K_NONE, 3);

    // Randomized key sequences, biased towards stable holds.
    cur = K_NONE;
    for (int f = 0; f < 80; f++) begin
      mode = $urandom_range(0, 9);
      if (mode >= 5 && mode <= 6) cur = K_NONE;
      else if (mode >= 7 && mode <= 8) cur = 12'(1) << $urandom_range(0, 11);
      else if (mode == 9) cur = (12'(1) << $urandom_range(0, 11)) | (12'(1) << $urandom_range(0, 11));
      run_frame(cur);
    end
    run_frames(K_NONE, 3);
    check_outputs();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
